regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Sole write-port controller for the 32x32 register file. Two requesters share the write port:
//   A = pipeline writeback, B = multi-cycle unit (load / mul-div). A 32-entry busy scoreboard
//   lets decode stall on operands whose writes are still pending.
//   Sits between the writeback sources and the reg32x32 writeaddr/we/writedata inputs.
// PARAMETERS
//   MAX_WAIT  3  consecutive cycles B may lose arbitration before it is forced to win (1..15)
// PORTS
//   clk            in   1   rising-edge clock
//   reset_n        in   1   asynchronous active-low reset
//   a_valid        in   1   requester A has a write
//   a_addr         in   5   A destination register
//   a_data         in   32  A write data
//   a_ready        out  1   A write accepted this cycle
//   b_valid        in   1   requester B has a write
//   b_addr         in   5   B destination register
//   b_data         in   32  B write data
//   b_ready        out  1   B write accepted this cycle
//   rsv_valid      in   1   issue-time reservation of a destination
//   rsv_addr       in   5   register being reserved
//   rd1_addr       in   5   decode read address 1
//   rd2_addr       in   5   decode read address 2
//   rd1_busy       out  1   busy[rd1_addr] (combinational)
//   rd2_busy       out  1   busy[rd2_addr] (combinational)
//   rf_we          out  1   to regfile we (registered)
//   rf_writeaddr   out  5   to regfile writeaddr (registered)
//   rf_writedata   out  32  to regfile writedata (registered)
// BEHAVIOUR
//   Reset (async, reset_n=0): rf_we=0, rf_writeaddr=0, rf_writedata=0, busy[31:0]=0,
//   wait_cnt=0. a_ready=b_ready=0 while reset_n=0.
//   Grant (combinational, one per cycle):
//   - Only A valid -> A. Only B valid -> B.
//   - Both valid -> A, unless wait_cnt==MAX_WAIT, in which case B wins.
//   - x_ready = grant to x. A transfer occurs when x_valid & x_ready at the clock edge.
//   - A requester must hold addr/data stable while valid & !ready.
//   wait_cnt (4 bit):
//   - Cleared when B is granted or b_valid=0.
//   - Incremented when b_valid & !b_ready; saturates at MAX_WAIT.
//   Write stage: transfer at edge N -> rf_we=1, rf_writeaddr/rf_writedata = granted addr/data
//   after edge N. Regfile commits at edge N+1. No transfer -> rf_we=0 and addr/data hold.
//   Register 0: the transfer is accepted (ready=1) but rf_we stays 0; busy[0] is always 0.
//   Scoreboard:
//   - rsv_valid & rsv_addr!=0 sets busy[rsv_addr].
//   - An edge with rf_we=1 clears busy[rf_writeaddr]; this is the regfile commit edge.
//   - Same edge set and clear on the same address -> set wins (newer producer).
//   - Reserving an already-busy register leaves it busy.
//   - rdN_busy = busy[rdN_addr]. Reading address 0 always returns 0.
//   Throughput: one write per cycle sustained. Accept-to-commit is 1 edge; busy drops at commit.
//   Reset mid-operation discards any registered write (rf_we=0) and clears all reservations.
// CONFIGURATION
//   STARVE_GUARD_EN defined: wait_cnt and the forced-B grant are implemented as above.
//   Not defined: strict fixed priority, A always beats B. wait_cnt is absent, MAX_WAIT is
//   ignored, and B can starve under continuous A traffic.
// TESTING
//   1 Reset: assert reset_n=0 mid-write (rf_we=1) -> rf_we=0, rd1_busy=rd2_busy=0 immediately.
//   2 A only: a_valid=1, addr=5, data=DEADBEEF at edge N -> a_ready=1;
//     after edge N rf_we=1, addr=5, data=DEADBEEF; after edge N+1 rf_we=0.
//   3 Contention, guard on, MAX_WAIT=3: A and B valid every cycle -> A,A,A,B,A,A,A,B...
//     Guard off -> B is never granted.
//   4 Reg 0: b_valid with addr=0 -> b_ready=1, rf_we stays 0.
//     rsv_addr=0 -> rd1_busy(rd1_addr=0)=0.
//   5 Scoreboard: rsv 9 -> rd1_busy=1 from the next cycle. A writes 9 -> busy stays 1 until
//     the commit edge, then 0. Re-reserve 9 on the commit edge -> busy stays 1.
//   6 Back-to-back: A writes r1,r2,r3 on consecutive cycles -> three consecutive rf_we pulses
//     with matching addr/data, no bubbles.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Sole write-port controller for the 32x32 register file. Two requesters share
//   the write port: A (pipeline writeback) and B (multi-cycle load / mul-div
//   unit). A 32-entry busy scoreboard lets decode stall on operands whose writes
//   are still pending.
//
//   Configuration macro: STARVE_GUARD_EN
//     defined     : B is forced to win after losing MAX_WAIT consecutive cycles.
//     not defined : strict fixed priority, A always beats B (B may starve).
//
// Ports
//   clk, reset_n                 rising-edge clock, async active-low reset
//   a_valid/a_addr/a_data        requester A write request
//   a_ready                      A accepted this cycle (combinational grant)
//   b_valid/b_addr/b_data        requester B write request
//   b_ready                      B accepted this cycle (combinational grant)
//   rsv_valid/rsv_addr           issue-time reservation of a destination register
//   rd1_addr/rd2_addr            decode read addresses
//   rd1_busy/rd2_busy            pending-write flags for the read addresses
//   rf_we/rf_writeaddr/rf_writedata  registered write port to the register file
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  input  logic [4:0]  rd1_addr,
  input  logic [4:0]  rd2_addr,
  output logic        rd1_busy,
  output logic        rd2_busy,
  output logic        rf_we,
  output logic [4:0]  rf_writeaddr,
  output logic [31:0] rf_writedata
);

  logic        grant_a_s;
  logic        grant_b_s;
  logic        force_b_s;
  logic [31:0] busy_r;
  logic [31:0] busy_next_s;

  // Elaboration-time range check on the starvation limit
  if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
    $error("regfile_wb_arbiter: MAX_WAIT must be within 1..15");
  end

`ifdef STARVE_GUARD_EN
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_r;

  // Starvation counter: consecutive cycles B was valid but lost arbitration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r <= 4'd0;
    end else if (!b_valid || grant_b_s) begin
      wait_cnt_r <= 4'd0;
    end else if (wait_cnt_r != WAIT_LIMIT) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign force_b_s = (wait_cnt_r == WAIT_LIMIT);
`else
  assign force_b_s = 1'b0;
`endif

  // Single-winner grant; nothing is granted while reset is asserted
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (!reset_n) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else if (a_valid && b_valid) begin
      if (force_b_s) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b1;
      end
    end else if (a_valid) begin
      grant_a_s = 1'b1;
    end else if (b_valid) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  // Write stage: a grant implies a transfer; writes to r0 are accepted but dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we        <= 1'b0;
      rf_writeaddr <= 5'd0;
      rf_writedata <= 32'd0;
    end else if (grant_a_s) begin
      rf_we        <= (a_addr != 5'd0);
      rf_writeaddr <= a_addr;
      rf_writedata <= a_data;
    end else if (grant_b_s) begin
      rf_we        <= (b_addr != 5'd0);
      rf_writeaddr <= b_addr;
      rf_writedata <= b_data;
    end else begin
      rf_we        <= 1'b0;
      rf_writeaddr <= rf_writeaddr;
      rf_writedata <= rf_writedata;
    end
  end

  // Scoreboard update: commit clears first, then a new reservation sets, so a
  // newer producer on the commit edge keeps the register busy
  always_comb begin
    busy_next_s = busy_r;
    if (rf_we) begin
      busy_next_s[rf_writeaddr] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (rsv_valid && (rsv_addr != 5'd0)) begin
      busy_next_s[rsv_addr] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
    busy_next_s[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign rd1_busy = busy_r[rd1_addr] & (rd1_addr != 5'd0);
  assign rd2_busy = busy_r[rd2_addr] & (rd2_addr != 5'd0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter. Drivers push expected register-file
//   writes (with the cycle they must appear) into a queue; a monitor on the
//   falling edge pops and compares them against rf_we/rf_writeaddr/rf_writedata.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [4:0]  rd1_addr;
  logic [4:0]  rd2_addr;
  logic        rd1_busy;
  logic        rd2_busy;
  logic        rf_we;
  logic [4:0]  rf_writeaddr;
  logic [31:0] rf_writedata;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  cyc    = 0;
  int  n_cmp  = 0;
  int  n_err  = 0;

  regfile_wb_arbiter #(.MAX_WAIT(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .rd1_addr     (rd1_addr),
    .rd2_addr     (rd2_addr),
    .rd1_busy     (rd1_busy),
    .rd2_busy     (rd2_busy),
    .rf_we        (rf_we),
    .rf_writeaddr (rf_writeaddr),
    .rf_writedata (rf_writedata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected write appears on the port after the coming edge
  task automatic push_wr(input logic [4:0] addr, input logic [31:0] data);
    wr_t e;
    if (addr != 5'd0) begin
      e.due  = cyc + 1;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the write port against the scoreboard every cycle
  always @(negedge clk) begin
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("wr_missed_due", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("rf_we", {31'd0, rf_we}, 32'd1);
        chk("rf_writeaddr", {27'd0, rf_writeaddr}, {27'd0, exp_q[0].addr});
        chk("rf_writedata", rf_writedata, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        chk("rf_we_idle", {31'd0, rf_we}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_b;
    int          ka;
    logic [31:0] bd;

    reset_n = 1'b1; a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
    rsv_valid = 1'b0; rsv_addr = 5'd0; rd1_addr = 5'd0; rd2_addr = 5'd0;

    // Reset state; ready stays low while in reset even with a request pending
    #1 reset_n = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h0000_0003;
    b_valid = 1'b1; b_addr = 5'd4;
    rd1_addr = 5'd3; rd2_addr = 5'd4;
    #1;
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rf_addr", {27'd0, rf_writeaddr}, 32'd0);
    chk("rst_rf_data", rf_writedata, 32'd0);
    chk("rst_rd1_busy", {31'd0, rd1_busy}, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();

    // A only: r5 <= DEADBEEF, one-cycle rf_we pulse
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    chk("a_only_a_ready", {31'd0, a_ready}, 32'd1);
    chk("a_only_b_ready", {31'd0, b_ready}, 32'd0);
    push_wr(5'd5, 32'hDEAD_BEEF);
    step();
    a_valid = 1'b0;
    chk("a_only_we_N", {31'd0, rf_we}, 32'd1);
    chk("a_only_addr_N", {27'd0, rf_writeaddr}, 32'd5);
    chk("a_only_data_N", rf_writedata, 32'hDEAD_BEEF);
    step();
    chk("a_only_we_N1", {31'd0, rf_we}, 32'd0);

    // Back-to-back: r1, r2, r3 on consecutive cycles, no bubbles
    for (int i = 1; i <= 3; i++) begin
      a_valid = 1'b1; a_addr = 5'(i); a_data = 32'h1111_0000 + 32'(i);
      #1;
      chk("b2b_a_ready", {31'd0, a_ready}, 32'd1);
      push_wr(5'(i), 32'h1111_0000 + 32'(i));
      step();
    end
    a_valid = 1'b0;
    step();

    // Register 0: accepted but never written, never busy
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0BAD_0000;
    rsv_valid = 1'b1; rsv_addr = 5'd0; rd1_addr = 5'd0;
    #1;
    chk("r0_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0; rsv_valid = 1'b0;
    chk("r0_rf_we", {31'd0, rf_we}, 32'd0);
    chk("r0_rd1_busy", {31'd0, rd1_busy}, 32'd0);
    step();

    // Scoreboard: reserve r9, write r9, busy clears on commit edge
    rsv_valid = 1'b1; rsv_addr = 5'd9; rd1_addr = 5'd9; rd2_addr = 5'd9;
    #1;
    chk("sb_busy_before_rsv", {31'd0, rd1_busy}, 32'd0);
    step();
    rsv_valid = 1'b0;
    chk("sb_busy_after_rsv", {31'd0, rd1_busy}, 32'd1);
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0099;
    #1;
    push_wr(5'd9, 32'h0000_0099);
    step();
    a_valid = 1'b0;
    chk("sb_busy_pre_commit", {31'd0, rd1_busy}, 32'd1);
    step();
    chk("sb_rd1_after_commit", {31'd0, rd1_busy}, 32'd0);
    chk("sb_rd2_after_commit", {31'd0, rd2_busy}, 32'd0);
    // Re-reserve r9 exactly on the commit edge: set wins
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    step();
    rsv_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0077;
    #1;
    push_wr(5'd9, 32'h0000_0077);
    step();
    a_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    step();
    rsv_valid = 1'b0;
    chk("sb_rersv_busy", {31'd0, rd1_busy}, 32'd1);
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0055;
    #1;
    push_wr(5'd9, 32'h0000_0055);
    step();
    a_valid = 1'b0;
    step();
    chk("sb_final_clear", {31'd0, rd2_busy}, 32'd0);

    // Contention: A and B valid every cycle
    ka = 0; bd = 32'hB0B0_0000;
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_addr = 5'(10 + ka); a_data = 32'hA000_0000 + 32'(ka);
      b_valid = 1'b1; b_addr = 5'd20; b_data = bd;
`ifdef STARVE_GUARD_EN
      exp_b = ((i % 4) == 3);
`else
      exp_b = 1'b0;
`endif
      #1;
      chk("cont_a_ready", {31'd0, a_ready}, {31'd0, ~exp_b});
      chk("cont_b_ready", {31'd0, b_ready}, {31'd0, exp_b});
      if (exp_b) begin
        push_wr(5'd20, bd);
        bd = bd + 32'd1;
      end else begin
        push_wr(5'(10 + ka), 32'hA000_0000 + 32'(ka));
        ka++;
      end
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step(); step();

    // Reset while a write sits on the port discards it and clears reservations
    rsv_valid = 1'b1; rsv_addr = 5'd7; rd1_addr = 5'd7; rd2_addr = 5'd7;
    step();
    rsv_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hCAFE_0007;
    #1;
    push_wr(5'd7, 32'hCAFE_0007);
    step();
    a_valid = 1'b0;
    chk("mid_rst_we_before", {31'd0, rf_we}, 32'd1);
    chk("mid_rst_busy_before", {31'd0, rd1_busy}, 32'd1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
    chk("mid_rst_rd1_busy", {31'd0, rd1_busy}, 32'd0);
    chk("mid_rst_rd2_busy", {31'd0, rd2_busy}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    step(); step();
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
